// File: rtl/ysyx_23060201_dmem_resp.sv
// ysyx_23060201_dmem_resp
// Fixed-latency data memory behind a valid/ready request channel and a
// valid/ready response channel. One transaction is in flight at a time:
// a request is accepted in IDLE, waits LAT cycles in WAIT, then its
// response is held in RESP until the consumer takes it.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset (storage is not cleared)
//   req_valid_i  request present
//   req_ready_o  high only while idle
//   req_wen_i    1 = store, 0 = load
//   req_addr_i   byte address
//   req_wmask_i  store size code: 0x01 byte, 0x03 half, 0x0F word
//   req_wdata_i  store data, right-aligned
//   req_rmask_i  load size code in [3:0], sign-extend flag in [4]
//   rsp_valid_o  response present
//   rsp_ready_i  consumer accepts the response
//   rsp_rdata_o  load data, right-aligned and extended (0 for stores/errors)
//   rsp_err_o    request was out of range, misaligned or had a bad mask
module ysyx_23060201_dmem_resp #(
  parameter int                        DATA_WIDTH     = 32,
  parameter int                        MEM_ADDR_WIDTH = 32,
  parameter int                        DEPTH          = 256,
  parameter logic [MEM_ADDR_WIDTH-1:0] BASE           = 32'h8000_0000,
  parameter int                        LAT            = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_wen_i,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [7:0]                req_wmask_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [7:0]                req_rmask_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        wen_q;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                  wmask_q;
  logic [7:0]                  rmask_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [DATA_WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]       mem_q [DEPTH];

  logic                        accept;
  logic                        exec;
  logic [MEM_ADDR_WIDTH-1:0]   offset;
  logic [MEM_ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]                  lane;
  logic [3:0]                  size;
  logic                        mask_ok;
  logic                        align_ok;
  logic                        range_ok;
  logic                        err;
  logic [DATA_WIDTH-1:0]       rd_word;
  logic [DATA_WIDTH-1:0]       rd_shifted;
  logic [DATA_WIDTH-1:0]       load_val;
  logic [3:0]                  byte_en;
  logic [DATA_WIDTH-1:0]       wdata_shifted;
  logic                        commit_store;

  // Decode the latched request: legality, word index, lane, and the
  // load/store data paths. Everything here works on the captured copy so
  // the request inputs are free to change after acceptance.
  always_comb begin
    offset   = addr_q - BASE;
    word_idx = offset >> 2;
    lane     = addr_q[1:0];
    size     = wen_q ? wmask_q[3:0] : rmask_q[3:0];
    // Upper mask bits carry no meaning other than rmask[4] (sign flag).
    mask_ok  = wen_q ? (wmask_q[7:4] == 4'b0000) : (rmask_q[7:5] == 3'b000);
    align_ok = 1'b0;
    case (size)
      4'b0001: align_ok = 1'b1;
      4'b0011: align_ok = ~lane[0];
      4'b1111: align_ok = (lane == 2'b00);
      default: mask_ok  = 1'b0;
    endcase
    range_ok = (addr_q >= BASE) && (word_idx < MEM_ADDR_WIDTH'(DEPTH));
    err      = ~(mask_ok & align_ok & range_ok);

    rd_word    = mem_q[word_idx[IDX_W-1:0]];
    rd_shifted = rd_word >> {lane, 3'b000};
    case (size)
      4'b0001: load_val = rmask_q[4] ? {{(DATA_WIDTH-8){rd_shifted[7]}}, rd_shifted[7:0]}
                                     : {{(DATA_WIDTH-8){1'b0}}, rd_shifted[7:0]};
      4'b0011: load_val = rmask_q[4] ? {{(DATA_WIDTH-16){rd_shifted[15]}}, rd_shifted[15:0]}
                                     : {{(DATA_WIDTH-16){1'b0}}, rd_shifted[15:0]};
      default: load_val = rd_shifted;
    endcase

    byte_en       = size << lane;
    wdata_shifted = wdata_q << {lane, 3'b000};
  end

  // Next-state logic. The counter is loaded with LAT-1 on acceptance and
  // the access executes on the cycle WAIT sees it at zero, which puts the
  // first rsp_valid exactly LAT edges after the accept edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    exec        = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          exec        = 1'b1;
          state_d     = RESP;
          rsp_err_d   = err;
          rsp_rdata_d = (err || wen_q) ? '0 : load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, captured request and held response. Reset aborts any
  // transaction in flight, which also prevents a pending store from
  // committing because the commit is qualified by being in WAIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wmask_q     <= 8'h00;
      rmask_q     <= 8'h00;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        wen_q   <= req_wen_i;
        addr_q  <= req_addr_i;
        wmask_q <= req_wmask_i;
        rmask_q <= req_rmask_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

  assign commit_store = exec && wen_q && !err;

  // Storage array: no reset, so contents survive rst_i. Stores land on
  // the WAIT-exit edge, one byte lane at a time.
  always_ff @(posedge clk_i) begin
    if (commit_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_q[word_idx[IDX_W-1:0]][8*b +: 8] <= wdata_shifted[8*b +: 8];
        end
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_23060201_dmem_resp.sv
// tb_ysyx_23060201_dmem_resp
// Self-checking bench for ysyx_23060201_dmem_resp: reset behaviour,
// a table of directed vectors, hand-written multi-cycle sequences
// (backpressure, reset mid-transaction) and randomized transactions
// compared against a byte-array reference model.
module tb_ysyx_23060201_dmem_resp;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          NV    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wmask;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_rmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int nVec  = 0;
  int nFail = 0;

  // Reference memory: one entry per byte, little-endian from BASE.
  logic [7:0] modelMem [4*DEPTH];

  typedef struct {
    string       name;
    logic        wen;
    logic [31:0] addr;
    logic [7:0]  wm;
    logic [31:0] wd;
    logic [7:0]  rm;
    logic [31:0] wantRd;
    logic        wantErr;
  } vec_t;

  vec_t vecs [NV];
  int   nvUsed = 0;

  always #5 clk = ~clk;

  ysyx_23060201_dmem_resp #(
    .DATA_WIDTH    (DW),
    .MEM_ADDR_WIDTH(AW),
    .DEPTH         (DEPTH),
    .BASE          (BASE),
    .LAT           (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wen_i   (req_wen),
    .req_addr_i  (req_addr),
    .req_wmask_i (req_wmask),
    .req_wdata_i (req_wdata),
    .req_rmask_i (req_rmask),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  // One comparison: counts it and reports a miscompare on one line.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nVec++;
    if (got !== want) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference model: works on bytes and sizes in plain arithmetic.
  // Updates modelMem for legal stores and returns the expected response.
  function automatic void refModel(input logic wen, input logic [31:0] addr, input logic [7:0] wm,
                                   input logic [31:0] wd, input logic [7:0] rm,
                                   output logic [31:0] rd, output logic er);
    longint     off;
    logic [7:0] m;
    int         n;
    longint     val;
    off = longint'(addr) - longint'(BASE);
    m   = wen ? wm : rm;
    case (m[3:0])
      4'h1:    n = 1;
      4'h3:    n = 2;
      4'hF:    n = 4;
      default: n = 0;
    endcase
    if (wen ? (m[7:4] != 4'h0) : (m[7:5] != 3'h0)) n = 0;
    if (n == 0) er = 1'b1;
    else er = (off < 0) || (off + n > 4*DEPTH) || (off % n != 0);
    rd = 32'h0;
    if (!er) begin
      if (wen) begin
        for (int i = 0; i < n; i++) modelMem[int'(off) + i] = wd[8*i +: 8];
      end else begin
        val = 0;
        for (int i = n - 1; i >= 0; i--) val = val * 256 + longint'(modelMem[int'(off) + i]);
        if (m[4] && n < 4 && val >= (longint'(1) << (8*n - 1))) val = val - (longint'(1) << (8*n));
        rd = val[31:0];
      end
    end
  endfunction

  task automatic addVec(input string name, input logic wen, input logic [31:0] addr, input logic [7:0] wm,
                        input logic [31:0] wd, input logic [7:0] rm, input logic [31:0] wantRd,
                        input logic wantErr);
    vecs[nvUsed].name    = name;
    vecs[nvUsed].wen     = wen;
    vecs[nvUsed].addr    = addr;
    vecs[nvUsed].wm      = wm;
    vecs[nvUsed].wd      = wd;
    vecs[nvUsed].rm      = rm;
    vecs[nvUsed].wantRd  = wantRd;
    vecs[nvUsed].wantErr = wantErr;
    nvUsed++;
  endtask

  // Runs one full transaction starting just after a rising edge: waits for
  // acceptance, measures the latency, holds the response for `stall`
  // cycles, then completes the handshake. Checks everything on the way.
  task automatic applyStimulus(input string name, input logic wen, input logic [31:0] addr,
                               input logic [7:0] wm, input logic [31:0] wd, input logic [7:0] rm,
                               input int stall, input logic [31:0] wantRd, input logic wantErr);
    int n;
    int lat;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wmask = wm;
    req_wdata = wd;
    req_rmask = rm;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checkOutput({name, " accept timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(LAT));
    if (!rsp_valid) return;
    checkOutput({name, " rdata"}, rsp_rdata, wantRd);
    checkOutput({name, " err"}, 32'(rsp_err), 32'(wantErr));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checkOutput({name, " held valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({name, " held rdata"}, rsp_rdata, wantRd);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput({name, " valid after handshake"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, " ready after handshake"}, 32'(req_ready), 32'd1);
  endtask

  // Same as applyStimulus, but the expectation comes from the model.
  task automatic modelTxn(input string name, input logic wen, input logic [31:0] addr,
                          input logic [7:0] wm, input logic [31:0] wd, input logic [7:0] rm,
                          input int stall);
    logic [31:0] wRd;
    logic        wErr;
    refModel(wen, addr, wm, wd, rm, wRd, wErr);
    applyStimulus(name, wen, addr, wm, wd, rm, stall, wRd, wErr);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wantRd;
    logic        wantErr;
    logic [31:0] oldVal;
    logic [3:0]  codes [3];
    logic [3:0]  sz;
    logic        wen;
    logic [31:0] addr;
    logic [7:0]  wm;
    logic [7:0]  rm;
    int          cyc;

    codes[0] = 4'h1;
    codes[1] = 4'h3;
    codes[2] = 4'hF;

    // Directed table: hand-computed expectations.
    addVec("rt store word",   1'b1, 32'h8000_0010, 8'h0F, 32'hDEAD_BEEF, 8'h00, 32'h0000_0000, 1'b0);
    addVec("rt load word",    1'b0, 32'h8000_0010, 8'h00, 32'h0,         8'h1F, 32'hDEAD_BEEF, 1'b0);
    addVec("lane base word",  1'b1, 32'h8000_0000, 8'h0F, 32'h1122_3344, 8'h00, 32'h0000_0000, 1'b0);
    addVec("lane store byte", 1'b1, 32'h8000_0003, 8'h01, 32'h0000_0080, 8'h00, 32'h0000_0000, 1'b0);
    addVec("lane word back",  1'b0, 32'h8000_0000, 8'h00, 32'h0,         8'h0F, 32'h8022_3344, 1'b0);
    addVec("lane byte signed",1'b0, 32'h8000_0003, 8'h00, 32'h0,         8'h11, 32'hFFFF_FF80, 1'b0);
    addVec("lane byte unsign",1'b0, 32'h8000_0003, 8'h00, 32'h0,         8'h01, 32'h0000_0080, 1'b0);
    addVec("half hi signed",  1'b0, 32'h8000_0002, 8'h00, 32'h0,         8'h13, 32'hFFFF_8022, 1'b0);
    addVec("half hi unsign",  1'b0, 32'h8000_0002, 8'h00, 32'h0,         8'h03, 32'h0000_8022, 1'b0);
    addVec("half lo signed",  1'b0, 32'h8000_0000, 8'h00, 32'h0,         8'h13, 32'h0000_3344, 1'b0);
    addVec("err word misal",  1'b1, 32'h8000_0002, 8'h0F, 32'hFFFF_FFFF, 8'h00, 32'h0000_0000, 1'b1);
    addVec("err past depth",  1'b0, 32'h8000_0400, 8'h00, 32'h0,         8'h0F, 32'h0000_0000, 1'b1);
    addVec("err below base",  1'b0, 32'h7FFF_FFFE, 8'h00, 32'h0,         8'h13, 32'h0000_0000, 1'b1);
    addVec("err half misal",  1'b1, 32'h8000_0001, 8'h03, 32'hFFFF_FFFF, 8'h00, 32'h0000_0000, 1'b1);
    addVec("err bad rmask",   1'b0, 32'h8000_0000, 8'h00, 32'h0,         8'h07, 32'h0000_0000, 1'b1);
    addVec("err bad wmask",   1'b1, 32'h8000_0000, 8'h07, 32'hFFFF_FFFF, 8'h00, 32'h0000_0000, 1'b1);
    addVec("mem unchanged",   1'b0, 32'h8000_0000, 8'h00, 32'h0,         8'h0F, 32'h8022_3344, 1'b0);
    addVec("top byte store",  1'b1, 32'h8000_03FF, 8'h01, 32'h0000_00AB, 8'h00, 32'h0000_0000, 1'b0);
    addVec("top byte load",   1'b0, 32'h8000_03FF, 8'h00, 32'h0,         8'h01, 32'h0000_00AB, 1'b0);
    addVec("top word store",  1'b1, 32'h8000_03FC, 8'h0F, 32'hCAFE_F00D, 8'h00, 32'h0000_0000, 1'b0);
    addVec("top half signed", 1'b0, 32'h8000_03FE, 8'h00, 32'h0,         8'h13, 32'hFFFF_CAFE, 1'b0);
    addVec("top word signed", 1'b0, 32'h8000_03FC, 8'h00, 32'h0,         8'h1F, 32'hCAFE_F00D, 1'b0);

    // Reset state, then a request presented as reset releases.
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'h0;
    req_wmask = 8'h00;
    req_wdata = 32'h0;
    req_rmask = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    checkOutput("release req_ready", 32'(req_ready), 32'd1);
    modelTxn("release store", 1'b1, BASE, 8'h0F, 32'h0BAD_F00D, 8'h00, 0);

    // Give every word a known value so the model covers the whole array.
    for (int w = 0; w < DEPTH; w++) begin
      modelTxn($sformatf("init%0d", w), 1'b1, BASE + 32'(4*w), 8'h0F, $urandom, 8'h00, 0);
    end

    // Directed table.
    for (int v = 0; v < nvUsed; v++) begin
      refModel(vecs[v].wen, vecs[v].addr, vecs[v].wm, vecs[v].wd, vecs[v].rm, wantRd, wantErr);
      applyStimulus(vecs[v].name, vecs[v].wen, vecs[v].addr, vecs[v].wm, vecs[v].wd, vecs[v].rm,
                    v % 3, vecs[v].wantRd, vecs[v].wantErr);
    end

    // Backpressure: response held 5 cycles while req_valid stays high.
    refModel(1'b0, 32'h8000_0008, 8'h00, 32'h0, 8'h0F, wantRd, wantErr);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0008;
    req_rmask = 8'h0F;
    rsp_ready = 1'b0;
    checkOutput("bp ready idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("bp ready in wait", 32'(req_ready), 32'd0);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("bp latency", 32'(cyc), 32'(LAT));
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      checkOutput("bp held valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp held rdata", rsp_rdata, wantRd);
      checkOutput("bp ready low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("bp valid after hs", 32'(rsp_valid), 32'd0);
    checkOutput("bp no accept at hs", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("bp second accept", 32'(req_ready), 32'd0);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("bp second latency", 32'(cyc), 32'(LAT));
    checkOutput("bp second rdata", rsp_rdata, wantRd);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during WAIT of a store: the store must be dropped.
    refModel(1'b0, 32'h8000_0020, 8'h00, 32'h0, 8'h0F, oldVal, wantErr);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wmask = 8'h0F;
    req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("midrst rsp_err", 32'(rsp_err), 32'd0);
    applyStimulus("midrst load old", 1'b0, 32'h8000_0020, 8'h00, 32'h0, 8'h0F, 0, oldVal, 1'b0);

    // Randomized transactions against the model.
    for (int i = 0; i < 300; i++) begin
      wen = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       addr = BASE - 32'($urandom_range(1, 16));
        1:       addr = BASE + 32'h400 + 32'($urandom_range(0, 64));
        default: addr = BASE + 32'($urandom_range(0, 4*DEPTH - 1));
      endcase
      if ($urandom_range(0, 7) == 0) sz = 4'($urandom_range(0, 15));
      else sz = codes[$urandom_range(0, 2)];
      wm = wen ? {4'h0, sz} : 8'($urandom_range(0, 255));
      rm = wen ? 8'($urandom_range(0, 255)) : {3'b000, 1'($urandom_range(0, 1)), sz};
      modelTxn($sformatf("rnd%0d", i), wen, addr, wm, $urandom, rm, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
